fp_mult_pack_stage: RTL and testbench

- Downstream stage of the approximate FP32 multiplier datapath.
- Takes the two original operands, plus the `normalised` flag and 23-bit `product_mantissa` from the combinational mantissa unit, in the same cycle.
- Computes sign and biased exponent, detects special cases and overflow/underflow, and packs the IEEE-754 single-precision result.
- Two-stage registered pipeline with valid/ready handshake on both sides, plus sticky status flags for software.

---
 rtl/fp_mult_pkg.sv | 22 ++
 rtl/fp_pipe_reg.sv | 34 +++
 rtl/fp_mult_pack_stage.sv | 146 ++++++++++++++
 tb/tb_fp_mult_pack_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mult_pkg.sv
// Shared constants and pack-case encoding for the approximate FP32 multiplier datapath.
package fp_mult_pkg;

  localparam int EXP_W   = 8;
  localparam int MANT_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  // Bit positions inside the {exception, overflow, underflow} flag vector
  localparam int FLG_EXC = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UDF = 0;

  typedef enum logic [2:0] {
    PK_NORM = 3'd0,
    PK_EXC  = 3'd1,
    PK_ZERO = 3'd2,
    PK_OVF  = 3'd3,
    PK_UDF  = 3'd4
  } pack_case_e;

endpackage

// File: rtl/fp_pipe_reg.sv
// Parameterised-width valid/ready pipeline register; holds its beat while downstream stalls.
module fp_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_reg;
  logic [W-1:0] data_reg;

  assign in_ready  = !valid_reg || out_ready;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (in_ready) begin
      valid_reg <= in_valid;
      if (in_valid) begin
        data_reg <= in_data;
      end
    end
  end

endmodule

// File: rtl/fp_mult_pack_stage.sv
// Sign/exponent computation, special-case detection and IEEE-754 packing for the
// approximate FP32 multiplier, as a two-stage valid/ready pipeline with sticky flags.
module fp_mult_pack_stage #(
  parameter int EXP_W  = fp_mult_pkg::EXP_W,
  parameter int MANT_W = fp_mult_pkg::MANT_W,
  parameter int BIAS   = fp_mult_pkg::BIAS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [EXP_W+MANT_W:0]     a_operand,
  input  logic [EXP_W+MANT_W:0]     b_operand,
  input  logic                      normalised,
  input  logic [MANT_W-1:0]         product_mantissa,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+MANT_W:0]     result,
  output logic                      overflow,
  output logic                      underflow,
  output logic                      exception,
  input  logic                      clr_flags,
  output logic [2:0]                sticky_flags
);

  import fp_mult_pkg::*;

  localparam int DATA_W   = 1 + EXP_W + MANT_W;
  localparam int ESW      = EXP_W + 2;
  localparam int EXP_ONES = (1 << EXP_W) - 1;
  localparam int S1_W     = 1 + ESW + MANT_W + 4;
  localparam int S2_W     = DATA_W + 3;

  // ---------------- S1: sign, exponent sum, operand classification
  logic [EXP_W-1:0]  ea, eb;
  logic [MANT_W-1:0] ma, mb;
  logic [ESW-1:0]    exp_sum_next;
  logic [S1_W-1:0]   s1_in_data, s1_out_data;
  logic              s1_out_valid, s2_in_ready;

  assign ea = a_operand[DATA_W-2 -: EXP_W];
  assign eb = b_operand[DATA_W-2 -: EXP_W];
  assign ma = a_operand[MANT_W-1:0];
  assign mb = b_operand[MANT_W-1:0];

  // Modulo-2^ESW arithmetic; bits are reinterpreted as signed in S2
  assign exp_sum_next = {2'b00, ea} + {2'b00, eb} + ESW'(normalised) - ESW'(BIAS);

  assign s1_in_data = {a_operand[DATA_W-1] ^ b_operand[DATA_W-1],
                       exp_sum_next,
                       product_mantissa,
                       (ea == EXP_W'(EXP_ONES)),
                       (eb == EXP_W'(EXP_ONES)),
                       (ea == '0) && (ma == '0),
                       (eb == '0) && (mb == '0)};

  fp_pipe_reg #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in_data),
    .out_valid (s1_out_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_out_data)
  );

  // ---------------- S2: priority pack
  logic                     s1_sign, s1_a_inf, s1_b_inf, s1_a_zero, s1_b_zero;
  logic signed [ESW-1:0]    s1_exp_sum;
  logic [MANT_W-1:0]        s1_mant;
  pack_case_e               pack_case;
  logic [DATA_W-1:0]        result_next;
  logic [2:0]               flags_next;
  logic [S2_W-1:0]          s2_out_data;

  assign {s1_sign, s1_exp_sum, s1_mant, s1_a_inf, s1_b_inf, s1_a_zero, s1_b_zero} = s1_out_data;

  always_comb begin
    pack_case = PK_NORM;
    if (s1_a_inf || s1_b_inf) begin
      pack_case = PK_EXC;
    end else if (s1_a_zero || s1_b_zero) begin
      pack_case = PK_ZERO;
    end else if (s1_exp_sum >= EXP_ONES) begin
      pack_case = PK_OVF;
    end else if (s1_exp_sum <= 0) begin
      pack_case = PK_UDF;
    end
  end

  always_comb begin
    result_next = {s1_sign, s1_exp_sum[EXP_W-1:0], s1_mant};
    flags_next  = 3'b000;
    case (pack_case)
      PK_EXC: begin
        result_next        = {s1_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        flags_next[FLG_EXC] = 1'b1;
      end
      PK_ZERO: begin
        result_next = {s1_sign, {(DATA_W-1){1'b0}}};
      end
      PK_OVF: begin
        result_next        = {s1_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        flags_next[FLG_OVF] = 1'b1;
      end
      PK_UDF: begin
        result_next        = {s1_sign, {(DATA_W-1){1'b0}}};
        flags_next[FLG_UDF] = 1'b1;
      end
      default: ;
    endcase
  end

  fp_pipe_reg #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_out_valid),
    .in_ready  (s2_in_ready),
    .in_data   ({result_next, flags_next}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_out_data)
  );

  assign result    = s2_out_data[S2_W-1:3];
  assign exception = s2_out_data[FLG_EXC];
  assign overflow  = s2_out_data[FLG_OVF];
  assign underflow = s2_out_data[FLG_UDF];

  // ---------------- Sticky status; a clear beats a same-cycle flagged transfer
  logic [2:0] sticky_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_reg <= 3'b000;
    end else if (clr_flags) begin
      sticky_reg <= 3'b000;
    end else if (out_valid && out_ready) begin
      sticky_reg <= sticky_reg | s2_out_data[2:0];
    end
  end

  assign sticky_flags = sticky_reg;

endmodule

// File: tb/tb_fp_mult_pack_stage.sv
// Scoreboard bench for fp_mult_pack_stage: the driver queues hand-computed results,
// a monitor branch pops and compares each beat the DUT hands over.
module tb_fp_mult_pack_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_operand, b_operand;
  logic        normalised;
  logic [22:0] product_mantissa;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow, underflow, exception;
  logic        clr_flags;
  logic [2:0]  sticky_flags;

  typedef struct packed {
    logic [31:0] r;
    logic [2:0]  f;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          n_in = 0;
  int          n_out = 0;
  int          base;
  logic [31:0] held;

  always #5 clk = ~clk;

  fp_mult_pack_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .a_operand        (a_operand),
    .b_operand        (b_operand),
    .normalised       (normalised),
    .product_mantissa (product_mantissa),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .result           (result),
    .overflow         (overflow),
    .underflow        (underflow),
    .exception        (exception),
    .clr_flags        (clr_flags),
    .sticky_flags     (sticky_flags)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic n,
                      input logic [22:0] m, input logic [31:0] er, input logic [2:0] ef);
    bit done = 0;
    a_operand        = a;
    b_operand        = b;
    normalised       = n;
    product_mantissa = m;
    in_valid         = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{r: er, f: ef});
        n_in++;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=in_ready_low want=accept a=%h b=%h", a, b);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit empty = 0;
    for (int k = 0; k < 30 && !empty; k++) begin
      @(posedge clk);
      #1;
      empty = (sb.size() == 0);
    end
    if (!empty) begin
      total++;
      bad++;
      $display("FAIL drain_timeout got=%0d pending want=0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n            = 1'b0;
    in_valid         = 1'b0;
    a_operand        = '0;
    b_operand        = '0;
    normalised       = 1'b0;
    product_mantissa = '0;
    out_ready        = 1'b1;
    clr_flags        = 1'b0;

    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_beat got=%h want=none", result);
            end else begin
              mon_e = sb.pop_front();
              chk("beat_result", result, mon_e.r);
              chk("beat_flags", {29'd0, exception, overflow, underflow}, {29'd0, mon_e.f});
            end
            n_out++;
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {29'd0, exception, overflow, underflow}, 32'd0);
    chk("rst_sticky", {29'd0, sticky_flags}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Normal: 1.5 * 2.0 = 3.0
    send(32'h3FC00000, 32'h40000000, 1'b0, 23'h400000, 32'h40400000, 3'b000);
    idle();
    drain();
    chk("sticky_after_normal", {29'd0, sticky_flags}, 32'd0);

    // Overflow: exp_sum = 254 + 254 - 127 = 381
    send(32'h7F000000, 32'h7F000000, 1'b0, 23'd0, 32'h7F800000, 3'b010);
    idle();
    drain();
    chk("sticky_after_ovf", {29'd0, sticky_flags}, 32'b010);

    // Underflow with negative sign: exp_sum = 1 + 1 - 127
    send(32'h80800000, 32'h00800000, 1'b0, 23'd0, 32'h80000000, 3'b001);
    idle();
    drain();
    chk("sticky_after_udf", {29'd0, sticky_flags}, 32'b011);

    clr_flags = 1'b1;
    @(posedge clk);
    #1;
    clr_flags = 1'b0;
    chk("sticky_after_clr", {29'd0, sticky_flags}, 32'd0);

    // Inf * 0 reports exception only
    send(32'h7F800000, 32'h00000000, 1'b0, 23'd0, 32'h7F800000, 3'b100);
    idle();
    drain();
    chk("sticky_after_exc", {29'd0, sticky_flags}, 32'b100);

    // Back-to-back boundary vectors
    send(32'h7F000000, 32'h40000000, 1'b0, 23'h000111, 32'h7F800000, 3'b010); // exp_sum 255
    send(32'h1F800000, 32'h20000000, 1'b0, 23'h000222, 32'h00000000, 3'b001); // exp_sum 0
    send(32'h20000000, 32'h20000000, 1'b0, 23'h123456, 32'h00923456, 3'b000); // exp_sum 1
    send(32'h00000001, 32'h7F000000, 1'b1, 23'h000ABC, 32'h40000ABC, 3'b000); // denormal a
    send(32'h7F000000, 32'h3F800000, 1'b0, 23'h7FFFFF, 32'h7F7FFFFF, 3'b000); // exp_sum 254
    send(32'h3F800000, 32'hFFC00000, 1'b0, 23'h000001, 32'hFF800000, 3'b100); // NaN operand
    send(32'h80000000, 32'h3F800000, 1'b0, 23'h000005, 32'h80000000, 3'b000); // -0 * 1
    idle();
    drain();
    chk("sticky_accum", {29'd0, sticky_flags}, 32'b111);

    // Clear coinciding with an overflow transfer: clear wins
    out_ready = 1'b0;
    send(32'h7F000000, 32'h7F000000, 1'b0, 23'd0, 32'h7F800000, 3'b010);
    idle();
    for (int k = 0; k < 10 && !out_valid; k++) begin
      @(posedge clk);
      #1;
    end
    chk("clr_race_out_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    clr_flags = 1'b1;
    @(posedge clk);
    #1;
    clr_flags = 1'b0;
    chk("clr_race_sticky", {29'd0, sticky_flags}, 32'd0);
    drain();

    // Backpressure: four beats offered, only two fit while stalled
    out_ready = 1'b0;
    base = n_in;
    fork
      begin
        send(32'h3F800000, 32'h3F800000, 1'b0, 23'd1, 32'h3F800001, 3'b000);
        send(32'h3F800000, 32'h3F800000, 1'b0, 23'd2, 32'h3F800002, 3'b000);
        send(32'h3F800000, 32'h3F800000, 1'b0, 23'd3, 32'h3F800003, 3'b000);
        send(32'h3F800000, 32'h3F800000, 1'b0, 23'd4, 32'h3F800004, 3'b000);
        idle();
      end
    join_none
    repeat (5) @(posedge clk);
    #1;
    chk("bp_accepted", n_in - base, 32'd2);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    held = result;
    chk("bp_head", held, 32'h3F800001);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_hold", result, held);
    base = n_out;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("bp_drain_rate", n_out - base, 32'd4);
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(32'h3FC00000, 32'h40000000, 1'b0, 23'h400000, 32'h40400000, 3'b000);
    send(32'h7F000000, 32'h7F000000, 1'b0, 23'd0, 32'h7F800000, 3'b010);
    idle();
    chk("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sticky", {29'd0, sticky_flags}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    base = n_out;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_no_stale", n_out - base, 32'd0);
    send(32'h3FC00000, 32'h40000000, 1'b0, 23'h400000, 32'h40400000, 3'b000);
    idle();
    drain();
    chk("post_rst_beat", n_out - base, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
